// File: rtl/cache_pkg.sv
// Shared types for the direct-mapped write-through cache controller:
// FSM state encoding, tag-width derivation and the line record layout.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    MEM_RD  = 3'd2,
    MEM_WR  = 3'd3,
    RESP    = 3'd4
  } cache_state_t;

  function automatic int tag_w(input int awidth, input int index_w);
    return awidth - index_w;
  endfunction

  localparam int DEF_AWIDTH  = 9;
  localparam int DEF_DWIDTH  = 32;
  localparam int DEF_INDEX_W = 5;
  localparam int DEF_TAG_W   = tag_w(DEF_AWIDTH, DEF_INDEX_W);

  // Line record at the default geometry; the array stores the same fields per line.
  typedef struct packed {
    logic                  valid;
    logic [DEF_TAG_W-1:0]  tag;
    logic [DEF_DWIDTH-1:0] data;
  } cache_line_t;

endpackage

// File: rtl/cache_line_array.sv
// Flop-based one-word-per-line storage: combinational read by index, synchronous
// fill (valid+tag+data) or data-only update; reset clears only the valid bits.
module cache_line_array #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 4,
  parameter int DWIDTH  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DWIDTH-1:0]  rd_data,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic               fill_en,
  input  logic               data_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DWIDTH-1:0]  wr_data
);

  localparam int NLINES = 1 << INDEX_W;

  logic [NLINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  logic [TAG_W-1:0]  tag_d  [NLINES];
  logic [DWIDTH-1:0] data_q [NLINES];
  logic [DWIDTH-1:0] data_d [NLINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
    end
    if (fill_en || data_en) begin
      data_d[wr_idx] = wr_data;
    end
  end

  // Reset wins over a simultaneous fill so a dropped miss never leaves a valid line.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    if (!reset_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with saturating
// hit/miss counters. Read hit acks 1 cycle after accept; misses and writes ack after 3.
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 32,
  parameter int INDEX_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              rd_mem,
  output logic              wr_mem,
  output logic [AWIDTH-1:0] addr_mem,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int TAG_W = tag_w(AWIDTH, INDEX_W);

  cache_state_t      state_q, state_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               line_valid;
  logic [TAG_W-1:0]   line_tag;
  logic [DWIDTH-1:0]  line_data;
  logic               hit;
  logic               fill_en;
  logic               data_en;
  logic [DWIDTH-1:0]  line_wdata;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign idx        = addr_q[INDEX_W-1:0];
  assign tag        = addr_q[AWIDTH-1:INDEX_W];
  assign hit        = line_valid && (line_tag == tag);
  assign line_wdata = fill_en ? mem_rdata : wdata_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  cache_line_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DWIDTH  (DWIDTH)
  ) u_lines (
    .clk      (clk),
    .reset_n  (reset_n),
    .rd_idx   (idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_data  (line_data),
    .wr_idx   (idx),
    .fill_en  (fill_en),
    .data_en  (data_en),
    .wr_tag   (tag),
    .wr_data  (line_wdata)
  );

  // Memory-side outputs depend only on state_q and the latched request.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    cpu_ack    = 1'b0;
    cpu_rdata  = '0;
    rd_mem     = 1'b0;
    wr_mem     = 1'b0;
    addr_mem   = '0;
    mem_wdata  = '0;
    fill_en    = 1'b0;
    data_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) hit_cnt_d = sat_inc(hit_cnt_q);
        else     miss_cnt_d = sat_inc(miss_cnt_q);
        if (we_q) begin
          data_en = hit;
          state_d = MEM_WR;
        end else if (hit) begin
          cpu_ack   = 1'b1;
          cpu_rdata = line_data;
          state_d   = IDLE;
        end else begin
          state_d = MEM_RD;
        end
      end
      MEM_RD: begin
        rd_mem   = 1'b1;
        addr_mem = addr_q;
        fill_en  = 1'b1;
        state_d  = RESP;
      end
      MEM_WR: begin
        wr_mem    = 1'b1;
        addr_mem  = addr_q;
        mem_wdata = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        cpu_ack = 1'b1;
        if (!we_q) cpu_rdata = line_data;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed vector table plus randomized traffic against an address-level cache model.
module tb_dm_cache_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          rd_mem;
  logic          wr_mem;
  logic [AW-1:0] addr_mem;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] mem     [1<<AW];
  logic [DW-1:0] ref_mem [1<<AW];
  int            cached  [1<<IW];

  always #5 clk = ~clk;

  dm_cache_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .INDEX_W(IW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .rd_mem    (rd_mem),
    .wr_mem    (wr_mem),
    .addr_mem  (addr_mem),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  // main_memory: commands latched on the falling edge
  always @(negedge clk) begin
    if (rd_mem) mem_rdata = mem[addr_mem];
    if (wr_mem) mem[addr_mem] = mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Caller is just after a rising edge with the DUT idle. lat counts cycles from accept edge.
  task automatic run_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int lat, output logic [DW-1:0] rd, output int nrd,
                         output int nwr, output logic [AW-1:0] maddr,
                         output logic [DW-1:0] mwd, output int viol);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    lat = -1; rd = '0; nrd = 0; nwr = 0; maddr = '0; mwd = '0; viol = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rd_mem && wr_mem) viol++;
      if (rd_mem) begin nrd++; maddr = addr_mem; end
      if (wr_mem) begin nwr++; maddr = addr_mem; mwd = mem_wdata; end
      if (!cpu_ack && cpu_rdata != '0) viol++;
      if (cpu_ack) begin lat = c; rd = cpu_rdata; break; end
    end
    cpu_req = 1'b0;
    @(posedge clk); #1;
    if (cpu_ack || rd_mem || wr_mem || cpu_rdata != '0) viol++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            lat;
    logic [DW-1:0] rdata;
    int            nrd;
    int            nwr;
    int            hit;
    int            miss;
  } vec_t;

  vec_t vt [8];

  initial begin
    int lat, nrd, nwr, viol, hit_m, miss_m;
    logic [DW-1:0] rd, mwd;
    logic [AW-1:0] maddr;

    vt[0] = '{1'b0, 9'h023, 32'h0,        3, 32'hDEADBEEF, 1, 0, 0, 1};
    vt[1] = '{1'b0, 9'h023, 32'h0,        1, 32'hDEADBEEF, 0, 0, 1, 1};
    vt[2] = '{1'b1, 9'h023, 32'h12345678, 3, 32'h0,        0, 1, 2, 1};
    vt[3] = '{1'b0, 9'h023, 32'h0,        1, 32'h12345678, 0, 0, 3, 1};
    vt[4] = '{1'b0, 9'h003, 32'h0,        3, 32'hA5A5A5A5, 1, 0, 3, 2};
    vt[5] = '{1'b0, 9'h023, 32'h0,        3, 32'h12345678, 1, 0, 3, 3};
    vt[6] = '{1'b1, 9'h044, 32'h1,        3, 32'h0,        0, 1, 3, 4};
    vt[7] = '{1'b0, 9'h044, 32'h0,        3, 32'h1,        1, 0, 3, 5};

    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    mem[9'h023] = 32'hDEADBEEF;
    mem[9'h003] = 32'hA5A5A5A5;

    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, cpu_ack}, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_rd_mem", {31'b0, rd_mem}, 0);
    chk("rst_wr_mem", {31'b0, wr_mem}, 0);
    chk("rst_addr_mem", 32'(addr_mem), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_hit_cnt", 32'(hit_cnt), 0);
    chk("rst_miss_cnt", 32'(miss_cnt), 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_req(vt[i].we, vt[i].addr, vt[i].wdata, lat, rd, nrd, nwr, maddr, mwd, viol);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d_nrd", i), nrd, vt[i].nrd);
      chk($sformatf("v%0d_nwr", i), nwr, vt[i].nwr);
      if (vt[i].nrd + vt[i].nwr > 0) chk($sformatf("v%0d_addr_mem", i), 32'(maddr), 32'(vt[i].addr));
      if (vt[i].we) chk($sformatf("v%0d_mem_wdata", i), mwd, vt[i].wdata);
      chk($sformatf("v%0d_hit_cnt", i), 32'(hit_cnt), vt[i].hit);
      chk($sformatf("v%0d_miss_cnt", i), 32'(miss_cnt), vt[i].miss);
      chk($sformatf("v%0d_viol", i), viol, 0);
    end

    // Reset during MEM_RD of a cold read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h00A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midmiss_rd_mem", {31'b0, rd_mem}, 1);
    reset_n = 1'b0; cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("midmiss_ack", {31'b0, cpu_ack}, 0);
    chk("midmiss_rdata", cpu_rdata, 0);
    chk("midmiss_strobes", {30'b0, rd_mem, wr_mem}, 0);
    chk("midmiss_addr_mem", 32'(addr_mem), 0);
    chk("midmiss_mem_wdata", mem_wdata, 0);
    chk("midmiss_cnts", {24'b0, hit_cnt, miss_cnt}, 0);
    @(posedge clk); #1;
    chk("midmiss_ack2", {31'b0, cpu_ack}, 0);
    reset_n = 1'b1;
    run_req(1'b0, 9'h023, 32'h0, lat, rd, nrd, nwr, maddr, mwd, viol);
    chk("postrst_023_lat", lat, 3);
    chk("postrst_023_nrd", nrd, 1);
    chk("postrst_023_rdata", rd, 32'h12345678);
    chk("postrst_miss_cnt", 32'(miss_cnt), 1);
    run_req(1'b0, 9'h00A, 32'h0, lat, rd, nrd, nwr, maddr, mwd, viol);
    chk("postrst_00A_lat", lat, 3);
    chk("postrst_00A_rdata", rd, mem[9'h00A]);

    // Randomized traffic over a small address pool to force hits, conflicts and saturation
    do_reset();
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = mem[i];
    for (int i = 0; i < (1 << IW); i++) cached[i] = -1;
    hit_m = 0; miss_m = 0;
    for (int t = 0; t < 200; t++) begin
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            ix;
      bit            h;
      we = ($urandom_range(0, 2) == 0);
      a  = AW'(($urandom_range(0, 3) << IW) | $urandom_range(0, 7));
      d  = $urandom;
      ix = int'(a) % (1 << IW);
      h  = (cached[ix] == int'(a));
      if (h) hit_m = (hit_m < CMAX) ? hit_m + 1 : CMAX;
      else   miss_m = (miss_m < CMAX) ? miss_m + 1 : CMAX;
      run_req(we, a, d, lat, rd, nrd, nwr, maddr, mwd, viol);
      if (we) begin
        chk($sformatf("r%0d_wr_lat", t), lat, 3);
        chk($sformatf("r%0d_wr_nwr", t), {nrd[15:0], nwr[15:0]}, 1);
        chk($sformatf("r%0d_wr_addr", t), 32'(maddr), 32'(a));
        chk($sformatf("r%0d_wr_data", t), mwd, d);
        chk($sformatf("r%0d_wr_rdata", t), rd, 0);
        ref_mem[a] = d;
      end else begin
        chk($sformatf("r%0d_rd_lat", t), lat, h ? 3'd1 : 3'd3);
        chk($sformatf("r%0d_rd_strobes", t), {nrd[15:0], nwr[15:0]}, h ? 0 : 32'h10000);
        if (!h) chk($sformatf("r%0d_rd_addr", t), 32'(maddr), 32'(a));
        chk($sformatf("r%0d_rd_data", t), rd, ref_mem[a]);
        cached[ix] = int'(a);
      end
      chk($sformatf("r%0d_hit_cnt", t), 32'(hit_cnt), hit_m);
      chk($sformatf("r%0d_miss_cnt", t), 32'(miss_cnt), miss_m);
      chk($sformatf("r%0d_viol", t), viol, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
